red_secuencial_di: RTL and testbench

//  Sequential, right-to-left (LSB-first) magnitude comparator for two K-bit words.

---
 rtl/red_secuencial_di_pkg.sv | 25 ++
 rtl/red_secuencial_di_celda.sv | 21 ++
 rtl/red_secuencial_di.sv | 114 +++++++++++
 tb/tb_red_secuencial_di.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_secuencial_di_pkg.sv
// Shared definitions for the sequential LSB-first magnitude comparator:
// FSM state encodings, {M,N} result encodings and a width helper.
package red_secuencial_di_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MN_EQ = 2'b00;
    localparam logic [1:0] MN_GT = 2'b10;
    localparam logic [1:0] MN_LT = 2'b01;

    // Ceiling log2 that never drops below one bit, so K=1 still gets a counter.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/red_secuencial_di_celda.sv
// Combinational bit-cell: a differing bit pair overrides the partial {M,N},
// an equal pair passes it through unchanged.
module celda_secuencial
    import red_secuencial_di_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic m_in,
    input  logic n_in,
    output logic m_out,
    output logic n_out
);

    always_comb begin
        {m_out, n_out} = {m_in, n_in};
        if (a != b) begin
            {m_out, n_out} = a ? MN_GT : MN_LT;
        end
    end

endmodule

// File: rtl/red_secuencial_di.sv
// Sequential LSB-first magnitude comparator, one bit per clock.
// Optional trace outputs enabled by defining RED_SECUENCIAL_TRACE_EN.
module red_secuencial_di
    import red_secuencial_di_pkg::*;
#(
    parameter int K = 5
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         start,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         M,
    output logic         N,
    output logic         Z
`ifdef RED_SECUENCIAL_TRACE_EN
    ,
    output logic [clog2_min1(K)-1:0] trace_idx,
    output logic [1:0]               trace_mn
`endif
);

    localparam int            CW   = clog2_min1(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_t        r_state;
    state_t        w_stateNext;
    logic          w_load;
    logic [CW-1:0] r_cnt;
    logic [K-1:0]  r_sa;
    logic [K-1:0]  r_sb;
    logic          r_m;
    logic          r_n;
    logic          w_mNext;
    logic          w_nNext;

    celda_secuencial u_celda (
        .a     (r_sa[0]),
        .b     (r_sb[0]),
        .m_in  (r_m),
        .n_in  (r_n),
        .m_out (w_mNext),
        .n_out (w_nNext)
    );

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a start seen while done pulses is accepted.
                if (start) begin
                    w_stateNext = SHIFT;
                    w_load      = 1'b1;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_m     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_load) begin
                r_sa         <= A;
                r_sb         <= B;
                {r_m, r_n}   <= MN_EQ;
                r_cnt        <= '0;
            end else if (r_state == SHIFT) begin
                r_sa <= r_sa >> 1;
                r_sb <= r_sb >> 1;
                r_m  <= w_mNext;
                r_n  <= w_nNext;
                if (r_cnt != LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign M    = r_m;
    assign N    = r_n;
    assign Z    = r_m;

`ifdef RED_SECUENCIAL_TRACE_EN
    assign trace_idx = r_cnt;
    assign trace_mn  = {r_m, r_n};
`endif

endmodule

// File: tb/tb_red_secuencial_di.sv
// Directed bench for red_secuencial_di: a K=5 instance plus a K=1 instance
// sharing one clock, hand-computed results and latencies.
module tb_red_secuencial_di;

    logic       clk;
    logic       reset_L;
    logic       start;
    logic [4:0] A;
    logic [4:0] B;
    logic       busy, done, M, N, Z;

    logic       start1;
    logic [0:0] A1;
    logic [0:0] B1;
    logic       busy1, done1, M1, N1, Z1;

    int nCompared;
    int nMismatched;

`ifdef RED_SECUENCIAL_TRACE_EN
    logic [2:0] traceIdx;
    logic [1:0] traceMn;
    logic [0:0] traceIdx1;
    logic [1:0] traceMn1;
`endif

    red_secuencial_di #(.K(5)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .M       (M),
        .N       (N),
        .Z       (Z)
`ifdef RED_SECUENCIAL_TRACE_EN
        ,
        .trace_idx (traceIdx),
        .trace_mn  (traceMn)
`endif
    );

    red_secuencial_di #(.K(1)) dut1 (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start1),
        .A       (A1),
        .B       (B1),
        .busy    (busy1),
        .done    (done1),
        .M       (M1),
        .N       (N1),
        .Z       (Z1)
`ifdef RED_SECUENCIAL_TRACE_EN
        ,
        .trace_idx (traceIdx1),
        .trace_mn  (traceMn1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and waits (bounded) for done; latency counts the
    // accepting edge as edge 0, so K=5 should report 6.
    task automatic doOperation(input logic [4:0] a, input logic [4:0] b,
                               output int latency, output int busyCycles,
                               output logic gotDone);
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = 1'b0;
        latency = 1;
        busyCycles = 0;
        gotDone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            step();
            latency++;
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        #1;
        nCompared++;
        if ({busy, done, M, N, Z} !== 5'b00000) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000", {busy, done, M, N, Z});
        end
        nCompared++;
        if ({busy1, done1, M1, N1, Z1} !== 5'b00000) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs_k1: got %b expected 00000", {busy1, done1, M1, N1, Z1});
        end
        step();
        step();
        reset_L = 1'b1;
        step();
    endtask

    task automatic test_greater();
        int lat, bc;
        logic got;
        doOperation(5'b10110, 5'b01111, lat, bc, got);
        nCompared++;
        if (got !== 1'b1 || lat != 6) begin
            nMismatched++;
            $display("[TB] FAIL gt_latency: got done=%b latency=%0d expected done=1 latency=6", got, lat);
        end
        nCompared++;
        if (bc != 5) begin
            nMismatched++;
            $display("[TB] FAIL gt_busy_cycles: got %0d expected 5", bc);
        end
        nCompared++;
        if ({M, N, Z} !== 3'b101) begin
            nMismatched++;
            $display("[TB] FAIL gt_result: got MNZ=%b expected 101", {M, N, Z});
        end
        step();
        nCompared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL gt_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_equal_hold();
        int lat, bc;
        logic got;
        logic holdOk;
        doOperation(5'b10101, 5'b10101, lat, bc, got);
        nCompared++;
        if (got !== 1'b1 || lat != 6 || {M, N, Z} !== 3'b000) begin
            nMismatched++;
            $display("[TB] FAIL eq_result: got done=%b latency=%0d MNZ=%b expected 1 6 000", got, lat, {M, N, Z});
        end
        holdOk = 1'b1;
        A = 5'b11111;
        B = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({M, N, Z, done} !== 4'b0000) holdOk = 1'b0;
        end
        nCompared++;
        if (holdOk !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL eq_hold: got held=%b MNZ=%b expected held=1 MNZ=000", holdOk, {M, N, Z});
        end
    endtask

    task automatic test_less_and_lsb();
        int lat, bc;
        logic got;
        doOperation(5'b00011, 5'b10100, lat, bc, got);
        nCompared++;
        if (got !== 1'b1 || {M, N, Z} !== 3'b010) begin
            nMismatched++;
            $display("[TB] FAIL lt_result: got done=%b MNZ=%b expected 1 010", got, {M, N, Z});
        end
        step();
        doOperation(5'b00001, 5'b00000, lat, bc, got);
        nCompared++;
        if (got !== 1'b1 || {M, N, Z} !== 3'b101) begin
            nMismatched++;
            $display("[TB] FAIL lsb_result: got done=%b MNZ=%b expected 1 101", got, {M, N, Z});
        end
        step();
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic got;
        A = 5'b10110;
        B = 5'b01111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        A = 5'b00000;
        B = 5'b11111;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 4;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
            lat++;
        end
        nCompared++;
        if (got !== 1'b1 || lat != 6 || {M, N, Z} !== 3'b101) begin
            nMismatched++;
            $display("[TB] FAIL busy_start_ignored: got done=%b latency=%0d MNZ=%b expected 1 6 101", got, lat, {M, N, Z});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic got;
        A = 5'b00011;
        B = 5'b10100;
        start = 1'b1;
        step();
        A = 5'b10100;
        B = 5'b00011;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
            lat++;
        end
        nCompared++;
        if (got !== 1'b1 || lat != 6 || {M, N, Z} !== 3'b010) begin
            nMismatched++;
            $display("[TB] FAIL b2b_first: got done=%b latency=%0d MNZ=%b expected 1 6 010", got, lat, {M, N, Z});
        end
        step();
        nCompared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_restart: got busy=%b done=%b expected 1 0", busy, done);
        end
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
            lat++;
        end
        nCompared++;
        if (got !== 1'b1 || lat != 6 || {M, N, Z} !== 3'b101) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second: got done=%b latency=%0d MNZ=%b expected 1 6 101", got, lat, {M, N, Z});
        end
        start = 1'b0;
        step();
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        logic got;
        A = 5'b10110;
        B = 5'b01111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset_L = 1'b0;
        #1;
        nCompared++;
        if ({busy, done, M, N, Z} !== 5'b00000) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset: got %b expected 00000", {busy, done, M, N, Z});
        end
        step();
        reset_L = 1'b1;
        step();
        doOperation(5'b00011, 5'b10100, lat, bc, got);
        nCompared++;
        if (got !== 1'b1 || lat != 6 || {M, N, Z} !== 3'b010) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_op: got done=%b latency=%0d MNZ=%b expected 1 6 010", got, lat, {M, N, Z});
        end
        step();
    endtask

    task automatic test_k1();
        int lat;
        logic got;
        A1 = 1'b1;
        B1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done1) begin
                got = 1'b1;
                break;
            end
            step();
            lat++;
        end
        nCompared++;
        if (got !== 1'b1 || lat != 2 || {M1, N1, Z1} !== 3'b101) begin
            nMismatched++;
            $display("[TB] FAIL k1_result: got done=%b latency=%0d MNZ=%b expected 1 2 101", got, lat, {M1, N1, Z1});
        end
        step();
        nCompared++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL k1_idle: got done=%b busy=%b expected 0 0", done1, busy1);
        end
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        reset_L = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        start1 = 1'b0;
        A1 = '0;
        B1 = '0;
        #2;
        test_reset();
        test_greater();
        test_equal_hold();
        test_less_and_lsb();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_k1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
